wb_ram_arb: RTL and testbench

//  Parametrised N-port Wishbone-classic RAM: NPORTS slave ports share one synchronous single-port array.
//  A round-robin arbiter serialises the ports. Each port carries byte-select writes and full-word reads.

---
 rtl/wb_ram_pkg.sv | 21 ++
 rtl/wb_ram_arb_if.sv | 27 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/wb_ram_arb.sv | 118 +++++++++++
 tb/tb_wb_ram_arb.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ram_pkg.sv
// Shared types and elaboration helpers for the wb_ram_arb multi-port RAM.
package wb_ram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  // Index width for a count of items; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned lanes(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_ram_arb_if.sv
// Bundled per-port Wishbone-classic signals for wb_ram_arb; port p occupies slice p of each vector.
interface wb_ram_arb_if #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned AWIDTH = 15,
  parameter int unsigned DWIDTH = 32
);
  localparam int unsigned SW = DWIDTH / 8;

  logic [NPORTS-1:0]        cyc_i;
  logic [NPORTS-1:0]        stb_i;
  logic [NPORTS-1:0]        we_i;
  logic [NPORTS*SW-1:0]     sel_i;
  logic [NPORTS*AWIDTH-1:0] adr_i;
  logic [NPORTS*DWIDTH-1:0] dat_i;
  logic [NPORTS*DWIDTH-1:0] dat_o;
  logic [NPORTS-1:0]        ack_o;

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
    output dat_o, ack_o
  );

  modport master (
    output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr_i (mod N), plus the pointer that follows it.
module rr_arbiter
  import wb_ram_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic [IW-1:0] nxt_ptr_o
);
  logic found;

  always_comb begin
    int k;
    k         = 0;
    found     = 1'b0;
    gnt_o     = '0;
    idx_o     = '0;
    for (int i = 0; i < int'(N); i++) begin
      k = (int'(ptr_i) + i) % int'(N);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
    nxt_ptr_o = ptr_i;
    if (advance_i && found) begin
      nxt_ptr_o = (int'(idx_o) == int'(N) - 1) ? '0 : IW'(int'(idx_o) + 1);
    end
  end
endmodule

// File: rtl/wb_ram_arb.sv
// N-port Wishbone-classic RAM: round-robin arbitration onto one synchronous single-port array.
// Build option RAM_ARB_LOCK_EN: a granted port keeps the array while its cyc_i stays high.
module wb_ram_arb
  import wb_ram_pkg::*;
#(
  parameter int unsigned AWIDTH = 15,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NPORTS = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_ram_arb_if.slave bus
);
  localparam int unsigned SW    = lanes(DWIDTH);
  localparam int unsigned IW    = clog2(NPORTS);
  localparam int unsigned DEPTH = 2 ** AWIDTH;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NPORTS-1:0]   own_q, own_d;
  logic [NPORTS-1:0]   req, arb_req, gnt;
  logic [IW-1:0]       gidx, nxt_ptr;
  logic [AWIDTH-1:0]   adr;
  logic [DWIDTH-1:0]   wdat, rd_word_q, dat_word;
  logic [SW-1:0]       sel;
  logic                we, mem_en;
  logic [DWIDTH-1:0]   mem [DEPTH];

  assign req = bus.cyc_i & bus.stb_i;

`ifdef RAM_ARB_LOCK_EN
  logic lock_q, lock_d, locked;
  // Owner still holding cyc_i masks every other requester out of arbitration.
  assign locked  = lock_q && |(own_q & bus.cyc_i);
  assign arb_req = locked ? (req & own_q) : req;
  assign lock_d  = (state_q == IDLE) ? (|gnt || locked) : lock_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`else
  assign arb_req = req;
`endif

  rr_arbiter #(.N(NPORTS), .IW(IW)) u_arb (
    .req_i     (arb_req),
    .ptr_i     (ptr_q),
    .advance_i (state_q == IDLE),
    .gnt_o     (gnt),
    .idx_o     (gidx),
    .nxt_ptr_o (nxt_ptr)
  );

  // Steer the granted port's request fields onto the array.
  always_comb begin
    adr  = '0;
    wdat = '0;
    sel  = '0;
    we   = 1'b0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (gidx == IW'(p)) begin
        adr  = bus.adr_i[p*AWIDTH +: AWIDTH];
        wdat = bus.dat_i[p*DWIDTH +: DWIDTH];
        sel  = bus.sel_i[p*SW +: SW];
        we   = bus.we_i[p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    mem_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          mem_en  = 1'b1;
          ptr_d   = nxt_ptr;
          own_d   = gnt;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-before-write port with byte-lane enables.
  always_ff @(posedge clk_i) begin
    if (mem_en) begin
      rd_word_q <= mem[adr];
      if (we) begin
        for (int b = 0; b < int'(SW); b++) begin
          if (sel[b]) mem[adr][8*b +: 8] <= wdat[8*b +: 8];
        end
      end
    end
  end

  assign dat_word  = (state_q == ACK) ? rd_word_q : '0;
  assign bus.dat_o = {NPORTS{dat_word}};
  assign bus.ack_o = (state_q == ACK) ? (own_q & bus.cyc_i) : '0;

endmodule

// File: tb/tb_wb_ram_arb.sv
// Randomised and directed bench for wb_ram_arb (3 ports) against a transaction-level model.
module tb_wb_ram_arb;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_ram_arb_if #(.NPORTS(N), .AWIDTH(AW), .DWIDTH(DW)) bus ();

  wb_ram_arb #(.AWIDTH(AW), .DWIDTH(DW), .NPORTS(N)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // Master-side request state per port.
  bit          p_cyc [N];
  bit          p_stb [N];
  bit          p_we  [N];
  logic [3:0]  p_sel [N];
  logic [AW-1:0] p_adr [N];
  logic [DW-1:0] p_dat [N];
  int          p_left[N];

  // Reference model: memory with per-byte known flags, rr pointer, busy slot, lock owner.
  logic [DW-1:0] m_mem [1<<AW];
  logic [3:0]    m_bv  [1<<AW];
  int  m_ptr, m_own;
  bit  m_busy, m_lock;
  int  lose [N];

  int  total, bad;
  int  last_w;
  logic [DW-1:0] last_dat;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    for (int p = 0; p < N; p++) begin
      bus.cyc_i[p]           = p_cyc[p];
      bus.stb_i[p]           = p_stb[p];
      bus.we_i[p]            = p_we[p];
      bus.sel_i[p*4 +: 4]    = p_sel[p];
      bus.adr_i[p*AW +: AW]  = p_adr[p];
      bus.dat_i[p*DW +: DW]  = p_dat[p];
    end
  endtask

  task automatic issue(input int p, input bit we, input logic [3:0] sel,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat, input int n);
    p_cyc[p] = 1'b1; p_stb[p] = 1'b1; p_we[p] = we; p_sel[p] = sel;
    p_adr[p] = adr;  p_dat[p] = dat;  p_left[p] = n;
    apply();
  endtask

  // One clock: advance the model, compare ack/data, let the acked master move on.
  task automatic step();
    logic [N-1:0]  exp_ack, hold_ack;
    logic [DW-1:0] old, mask, got;
    int  w, ow;
    bit  lk;
    @(negedge clk);
    w = -1; exp_ack = '0; old = '0; mask = '0; lk = 1'b0;
    if (m_busy) m_busy = 1'b0;
    else begin
`ifdef RAM_ARB_LOCK_EN
      if (m_lock && p_cyc[m_own]) lk = 1'b1;
      else m_lock = 1'b0;
`endif
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (w < 0 && p_cyc[k] && p_stb[k] && (!lk || k == m_own)) w = k;
      end
      if (w >= 0) begin
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{m_bv[p_adr[w]][b]}};
        old = m_mem[p_adr[w]];
        if (p_we[w]) begin
          for (int b = 0; b < 4; b++) begin
            if (p_sel[w][b]) begin
              m_mem[p_adr[w]][8*b +: 8] = p_dat[w][8*b +: 8];
              m_bv[p_adr[w]][b] = 1'b1;
            end
          end
        end
        exp_ack[w] = 1'b1;
        m_ptr = (w + 1) % N; m_busy = 1'b1; m_lock = 1'b1; m_own = w;
      end
    end
    check("ack", bus.ack_o, exp_ack);
    ow = -1;
    for (int p = 0; p < N; p++) if (bus.ack_o[p]) ow = p;
`ifndef RAM_ARB_LOCK_EN
    if (ow >= 0) begin
      for (int p = 0; p < N; p++) if (p != ow && p_cyc[p] && p_stb[p]) lose[p]++;
      check("fairness", lose[ow] <= N - 1, 1);
      lose[ow] = 0;
    end
`endif
    if (w >= 0) begin
      got = bus.dat_o[w*DW +: DW];
      last_dat = got;
      if (mask != '0) check("rdata", got & mask, old & mask);
      p_left[w]--;
      if (p_left[w] <= 0) begin
        p_cyc[w] = 1'b0; p_stb[w] = 1'b0;
      end else begin
        p_adr[w] = AW'($urandom); p_dat[w] = $urandom;
      end
      apply();
      #1;
      hold_ack = '0; hold_ack[w] = p_cyc[w];
      check("ack_vs_cyc", bus.ack_o, hold_ack);
    end
    last_w = w;
  endtask

  task automatic run_until(input int p, output int cyc);
    bit seen;
    seen = 1'b0; cyc = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      step();
      if (last_w == p) begin seen = 1'b1; cyc = c; end
    end
    check("ack_seen", seen, 1);
  endtask

  task automatic pair(input int pa, input int pb, output int ca, output int cb);
    ca = 0; cb = 0;
    issue(pa, 1'b0, 4'hF, AW'($urandom), '0, 1);
    issue(pb, 1'b0, 4'hF, AW'($urandom), '0, 1);
    for (int c = 1; c <= 20 && (ca == 0 || cb == 0); c++) begin
      step();
      if (last_w == pa) ca = c;
      if (last_w == pb) cb = c;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < N; p++) begin
      p_cyc[p] = 1'b0; p_stb[p] = 1'b0; p_left[p] = 0; lose[p] = 0;
    end
    apply();
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", bus.ack_o, '0);
    check("rst_dat", bus.dat_o, '0);
    rst_n = 1'b1;
    m_ptr = 0; m_busy = 1'b0; m_lock = 1'b0; m_own = 0;
  endtask

  initial begin
    int c, ca, cb;
    int wq[$];
    int exp6[4];
    total = 0; bad = 0; last_w = -1;
    for (int a = 0; a < (1 << AW); a++) m_bv[a] = 4'h0;
    for (int p = 0; p < N; p++) begin
      p_cyc[p] = 1'b0; p_stb[p] = 1'b0; p_we[p] = 1'b0;
      p_sel[p] = '0; p_adr[p] = '0; p_dat[p] = '0; p_left[p] = 0;
    end
    apply();
    do_reset();

    // Single write then read-back, one-cycle latency each.
    issue(0, 1'b1, 4'hF, 8'd5, 32'hDEADBEEF, 1);
    run_until(0, c);
    check("t1_wr_latency", c, 1);
    step();
    issue(0, 1'b0, 4'hF, 8'd5, '0, 1);
    run_until(0, c);
    check("t1_rd_latency", c, 1);
    check("t1_rd_data", last_dat, 32'hDEADBEEF);

    // Byte-lane merge from a second port.
    step();
    issue(0, 1'b1, 4'hF, 8'd7, 32'h11223344, 1);
    run_until(0, c);
    step();
    issue(1, 1'b1, 4'b0101, 8'd7, 32'hAABBCCDD, 1);
    run_until(1, c);
    step();
    issue(2, 1'b0, 4'hF, 8'd7, '0, 1);
    run_until(2, c);
    check("t2_lane_merge", last_dat, 32'h11BB33DD);

    // Simultaneous requests: order follows the pointer.
    do_reset();
    pair(0, 1, ca, cb);
    check("t3_p0_first", ca, 1);
    check("t3_p1_second", cb, 3);
    step();
    issue(0, 1'b0, 4'hF, 8'd1, '0, 1);
    run_until(0, c);
    step();
    pair(0, 1, ca, cb);
    check("t3_p1_first", cb, 1);
    check("t3_p0_second", ca, 3);

    // All ports streaming: grants rotate 0,1,2,0,1,2.
    do_reset();
    for (int p = 0; p < N; p++) issue(p, 1'b0, 4'hF, AW'($urandom), '0, 2);
    for (int s = 0; s < 20 && wq.size() < 6; s++) begin
      step();
      if (last_w >= 0) wq.push_back(last_w);
    end
    check("t4_count", wq.size(), 6);
    foreach (wq[i]) check("t4_rr_order", wq[i], i % N);

    // Reset in the middle of an ACK cycle; memory survives, pointer restarts at 0.
    step();
    issue(2, 1'b1, 4'hF, 8'd9, 32'h0BADF00D, 1);
    run_until(2, c);
    step();
    issue(0, 1'b0, 4'hF, 8'd3, '0, 1);
    run_until(0, c);
    rst_n = 1'b0;
    #1;
    check("t5_ack_in_reset", bus.ack_o, '0);
    do_reset();
    pair(0, 2, ca, cb);
    check("t5_ptr0_p0", ca, 1);
    check("t5_ptr0_p2", cb, 3);
    step();
    issue(1, 1'b0, 4'hF, 8'd9, '0, 1);
    run_until(1, c);
    check("t5_mem_kept", last_dat, 32'h0BADF00D);

    // P0 holds cyc across three accesses while P1 waits.
    do_reset();
`ifdef RAM_ARB_LOCK_EN
    exp6 = '{0, 0, 0, 1};
`else
    exp6 = '{0, 1, 0, 0};
`endif
    wq.delete();
    issue(0, 1'b0, 4'hF, AW'($urandom), '0, 3);
    issue(1, 1'b0, 4'hF, AW'($urandom), '0, 1);
    for (int s = 0; s < 20 && wq.size() < 4; s++) begin
      step();
      if (last_w >= 0) wq.push_back(last_w);
    end
    check("t6_count", wq.size(), 4);
    foreach (wq[i]) if (i < 4) check("t6_order", wq[i], exp6[i]);

    // Fill every word so later reads are fully predictable.
    for (int a = 0; a < (1 << AW); a++) begin
      step();
      issue(a % N, 1'b1, 4'hF, AW'(a), $urandom, 1);
      run_until(a % N, c);
    end

    // Random traffic from all ports.
    for (int s = 0; s < 800; s++) begin
      step();
      for (int p = 0; p < N; p++) begin
        if (!p_cyc[p] && $urandom_range(0, 3) == 0)
          issue(p, 1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom), $urandom,
                int'($urandom_range(1, 3)));
      end
    end
    for (int s = 0; s < 60 && (p_cyc[0] || p_cyc[1] || p_cyc[2]); s++) step();
    check("drained", {p_cyc[0], p_cyc[1], p_cyc[2]}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
